// File: rtl/bram_fifo_ctrl_if.sv
// Write/read handshake bundle for the BRAM-backed FIFO controller.
// slave = FIFO side, master = producer/consumer side.
interface bram_fifo_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             wr_valid;
   logic             wr_ready;
   logic [WIDTH-1:0] wr_data;
   logic             rd_valid;
   logic             rd_ready;
   logic [WIDTH-1:0] rd_data;

   modport master (
      output wr_valid, wr_data, rd_ready,
      input  wr_ready, rd_valid, rd_data
   );

   modport slave (
      input  wr_valid, wr_data, rd_ready,
      output wr_ready, rd_valid, rd_data
   );
endinterface

// File: rtl/bram_fifo_ctrl.sv
// 1024-entry FIFO controller driving a single-port BRAM plus a 1-entry output stage.
// Optional occupancy port enabled by macro BRAM_FIFO_COUNT_EN.
module bram_fifo_ctrl #(
   parameter logic [2:0] BLOCK = 3'd0,
   parameter int         WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   bram_fifo_ctrl_if.slave  fifo,
   output logic             mem_enable,
   output logic             mem_write,
   output logic [2:0]       mem_block,
   output logic [10:0]      mem_addr,
   output logic [WIDTH-1:0] mem_data_in,
   input  logic [WIDTH-1:0] mem_data_out
`ifdef BRAM_FIFO_COUNT_EN
   ,
   output logic [10:0]      count
`endif
);

   typedef enum logic [1:0] {
      EMPTY,
      PENDING,
      FULL
   } stage_t;

   stage_t           stage;
   logic [9:0]       wptr;
   logic [9:0]       rptr;
   logic [10:0]      mem_count;
   logic [WIDTH-1:0] head;
   logic             rvalid;
   logic             read_issue;
   logic             wr_ready;
   logic             wr_fire;

   // Refilling the output stage always wins the single BRAM port.
   assign read_issue = (mem_count != 11'd0) &&
                       ((stage == EMPTY) ||
                        ((stage == FULL) && fifo.rd_ready));
   assign wr_ready   = !reset && !mem_count[10] && !read_issue;
   assign wr_fire    = fifo.wr_valid && wr_ready;

   assign fifo.wr_ready = wr_ready;
   assign fifo.rd_valid = rvalid;
   assign fifo.rd_data  = head;

   assign mem_enable  = read_issue || wr_fire;
   assign mem_write   = wr_fire;
   assign mem_block   = BLOCK;
   assign mem_addr    = {(read_issue ? rptr : wptr), 1'b0};
   assign mem_data_in = fifo.wr_data;

`ifdef BRAM_FIFO_COUNT_EN
   assign count = mem_count + {10'd0, (stage != EMPTY)};
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stage     <= EMPTY;
         wptr      <= '0;
         rptr      <= '0;
         mem_count <= '0;
         head      <= '0;
         rvalid    <= 1'b0;
      end else begin
         if (wr_fire)
            wptr <= wptr + 10'd1;
         if (read_issue)
            rptr <= rptr + 10'd1;
         mem_count <= mem_count + {10'd0, wr_fire} - {10'd0, read_issue};
         unique case (stage)
            EMPTY: begin
               if (read_issue)
                  stage <= PENDING;
            end
            PENDING: begin
               stage  <= FULL;
               head   <= mem_data_out;
               rvalid <= 1'b1;
            end
            FULL: begin
               if (fifo.rd_ready) begin
                  rvalid <= 1'b0;
                  stage  <= read_issue ? PENDING : EMPTY;
               end
            end
            default: begin
               stage  <= EMPTY;
               rvalid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Scoreboard bench for bram_fifo_ctrl with a behavioural BRAM model.
// Edges numbered from the write-accept edge t; outputs sampled on negedge.
module tb_bram_fifo_ctrl;
   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             mem_enable;
   logic             mem_write;
   logic [2:0]       mem_block;
   logic [10:0]      mem_addr;
   logic [WIDTH-1:0] mem_data_in;
   logic [WIDTH-1:0] mem_data_out = '0;
`ifdef BRAM_FIFO_COUNT_EN
   logic [10:0]      count;
`endif

   bram_fifo_ctrl_if #(.WIDTH(WIDTH)) bus ();

   bram_fifo_ctrl #(.BLOCK(3'd0), .WIDTH(WIDTH)) dut (
      .clk          (clk),
      .reset        (reset),
      .fifo         (bus),
      .mem_enable   (mem_enable),
      .mem_write    (mem_write),
      .mem_block    (mem_block),
      .mem_addr     (mem_addr),
      .mem_data_in  (mem_data_in),
      .mem_data_out (mem_data_out)
`ifdef BRAM_FIFO_COUNT_EN
      ,
      .count        (count)
`endif
   );

   always #5 clk = ~clk;

   logic [WIDTH-1:0] bram [2048];

   always @(posedge clk) begin
      if (mem_enable) begin
         if (mem_write)
            bram[mem_addr] <= mem_data_in;
         else
            mem_data_out <= bram[mem_addr];
      end
   end

   int               checks = 0;
   int               errors = 0;
   int               pops = 0;
   logic [WIDTH-1:0] last_pop = '0;
   logic [WIDTH-1:0] exp_q [$];
   logic [9:0]       wp = '0;
   logic [9:0]       rp = '0;
   bit               stream_chk = 1'b0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, act, req);
      end
   endtask

   // Monitor: scoreboard push on accepted write, pop on consumed head.
   always @(negedge clk) begin
      if (reset) begin
         exp_q.delete();
         wp = '0;
         rp = '0;
      end else begin
         if (mem_enable && mem_write) begin
            chk("wr_addr", {21'd0, mem_addr}, {21'd0, wp, 1'b0});
            wp++;
         end
         if (mem_enable && !mem_write) begin
            chk("rd_addr", {21'd0, mem_addr}, {21'd0, rp, 1'b0});
            rp++;
         end
         if (bus.wr_valid && bus.wr_ready)
            exp_q.push_back(bus.wr_data);
         if (bus.rd_valid && bus.rd_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL pop_empty: got %0h want none", bus.rd_data);
            end else begin
               chk("rd_data", {24'd0, bus.rd_data}, {24'd0, exp_q.pop_front()});
            end
            last_pop = bus.rd_data;
            pops++;
         end
         if (stream_chk)
            chk("wr_ready_vs_read", {31'd0, bus.wr_ready},
                {31'd0, !(mem_enable && !mem_write)});
      end
   end

   task automatic write_one(input logic [WIDTH-1:0] d);
      bit got;
      got = 1'b0;
      bus.wr_valid = 1'b1;
      bus.wr_data  = d;
      for (int n = 0; n < 4000; n++) begin
         @(negedge clk);
         if (bus.wr_ready) begin
            got = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
      bus.wr_valid = 1'b0;
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL write_timeout: got no wr_ready want accept of %0h", d);
      end
   endtask

   task automatic wait_pops(input int target, input int budget);
      for (int n = 0; n < budget; n++) begin
         @(negedge clk);
         if (pops >= target)
            break;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      reset        = 1'b1;
      bus.wr_valid = 1'b0;
      bus.rd_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      bus.wr_valid = 1'b0;
      bus.wr_data  = '0;
      bus.rd_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_wr_ready", {31'd0, bus.wr_ready}, 32'd0);
      chk("rst_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
      chk("rst_mem_enable", {31'd0, mem_enable}, 32'd0);
      chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
      chk("rst_mem_addr", {21'd0, mem_addr}, 32'd0);
      chk("rst_mem_block", {29'd0, mem_block}, 32'd0);
`ifdef BRAM_FIFO_COUNT_EN
      chk("rst_count", {21'd0, count}, 32'd0);
`endif
      reset = 1'b0;
      @(negedge clk);
      chk("wr_ready_after_rst", {31'd0, bus.wr_ready}, 32'd1);

      // Single write latency
      @(posedge clk);
      #1;
      bus.wr_valid = 1'b1;
      bus.wr_data  = 8'hA5;
      @(negedge clk);
      chk("lat_wr_en", {31'd0, mem_enable}, 32'd1);
      chk("lat_wr_we", {31'd0, mem_write}, 32'd1);
      chk("lat_wr_addr", {21'd0, mem_addr}, 32'd0);
      @(posedge clk);
      #1;
      bus.wr_valid = 1'b0;
      @(negedge clk);
      chk("lat_rd_en", {31'd0, mem_enable}, 32'd1);
      chk("lat_rd_we", {31'd0, mem_write}, 32'd0);
      chk("lat_rd_addr", {21'd0, mem_addr}, 32'd0);
      chk("lat_valid_t1", {31'd0, bus.rd_valid}, 32'd0);
      @(negedge clk);
      chk("lat_valid_pend", {31'd0, bus.rd_valid}, 32'd0);
      @(negedge clk);
      chk("lat_valid_t2", {31'd0, bus.rd_valid}, 32'd1);
      chk("lat_data_t2", {24'd0, bus.rd_data}, 32'hA5);
      @(posedge clk);
      #1;
      bus.rd_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.rd_ready = 1'b0;
      @(negedge clk);
      chk("lat_drained", {31'd0, bus.rd_valid}, 32'd0);

      // Fill to 1024 in memory plus 1 in the stage
      do_reset();
      for (int i = 0; i < 1025; i++)
         write_one(8'(i));
      @(negedge clk);
      chk("full_wr_ready", {31'd0, bus.wr_ready}, 32'd0);
      chk("full_rd_valid", {31'd0, bus.rd_valid}, 32'd1);
`ifdef BRAM_FIFO_COUNT_EN
      chk("full_count", {21'd0, count}, 32'd1025);
`endif
      @(posedge clk);
      #1;
      bus.wr_valid = 1'b1;
      bus.wr_data  = 8'h77;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("full_blocked", {31'd0, bus.wr_ready}, 32'd0);
      end
      @(posedge clk);
      #1;
      bus.wr_valid = 1'b0;
      bus.rd_ready = 1'b1;
      base = pops;
      @(negedge clk);
      chk("full_read_issue", {31'd0, mem_enable && !mem_write}, 32'd1);
      chk("full_issue_wr_ready", {31'd0, bus.wr_ready}, 32'd0);
      @(negedge clk);
      chk("full_freed", {31'd0, bus.wr_ready}, 32'd1);
      wait_pops(base + 1025, 4000);
      chk("full_drain_cnt", pops - base, 32'd1025);
      chk("full_q_empty", exp_q.size(), 32'd0);
      bus.rd_ready = 1'b0;

      // Ordered drain with one-cycle bubbles
      do_reset();
      for (int i = 0; i < 256; i++)
         write_one(8'(i));
      repeat (3) @(posedge clk);
      #1;
      base = pops;
      bus.rd_ready = 1'b1;
      for (int k = 0; k < 511; k++) begin
         @(negedge clk);
         chk("drain_pattern", {31'd0, bus.rd_valid}, {31'd0, (k % 2) == 0});
      end
      @(negedge clk);
      chk("drain_end_valid", {31'd0, bus.rd_valid}, 32'd0);
      chk("drain_end_en", {31'd0, mem_enable}, 32'd0);
      chk("drain_cnt", pops - base, 32'd256);
      chk("drain_last", {24'd0, last_pop}, 32'hFF);
      bus.rd_ready = 1'b0;

      // Streaming past pointer wrap
      do_reset();
      bus.rd_ready = 1'b1;
      stream_chk   = 1'b1;
      base = pops;
      for (int i = 0; i < 3000; i++)
         write_one(8'((i * 7 + 3) & 255));
      wait_pops(base + 3000, 8000);
      stream_chk = 1'b0;
      chk("stream_cnt", pops - base, 32'd3000);
      chk("stream_q_empty", exp_q.size(), 32'd0);
      bus.rd_ready = 1'b0;

      // Reset while a read is in flight
      do_reset();
      for (int i = 0; i < 6; i++)
         write_one(8'(8'h40 + i));
      repeat (3) @(posedge clk);
      #1;
      bus.rd_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.rd_ready = 1'b0;
      reset = 1'b1;
      #1;
      chk("midrst_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
      chk("midrst_mem_en", {31'd0, mem_enable}, 32'd0);
      chk("midrst_wr_ready", {31'd0, bus.wr_ready}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      write_one(8'h3C);
      bus.rd_ready = 1'b1;
      base = pops;
      wait_pops(base + 1, 20);
      chk("midrst_pops", pops - base, 32'd1);
      chk("midrst_first", {24'd0, last_pop}, 32'h3C);
      bus.rd_ready = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/bram_fifo_ctrl.md
BRAM_FIFO_CTRL -- requirements
Module: bram_fifo_ctrl

Interface
REQ-001 SHALL have parameter BLOCK, default 0: block-select value driven on mem_block for every access.
REQ-002 SHALL have parameter WIDTH, default 8: entry width in bits, 1..32.
REQ-003 SHALL have one clock, clk, and an asynchronous, active-high reset, reset.
REQ-004 Port clk, input, 1: rising-edge clock for all state.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port wr_valid, input, 1: write request. Port wr_ready, output, 1: write accepted this cycle when both high.
REQ-007 Port wr_data, input, WIDTH: write entry.
REQ-008 Port rd_valid, output, 1: head entry available. Port rd_ready, input, 1: head consumed when both high.
REQ-009 Port rd_data, output, WIDTH: head entry, held stable while rd_valid && !rd_ready.
REQ-010 Ports mem_enable, output, 1; mem_write, output, 1; mem_block, output, 3; mem_addr, output, 11; mem_data_in, output, WIDTH: single-port BRAM drive.
REQ-011 Port mem_data_out, input, WIDTH: BRAM read data, valid one cycle after a read access.

Function
REQ-012 SHALL store 1024 entries; 10-bit pointers; mem_addr[10:1] SHALL be the pointer and mem_addr[0] SHALL be 0.
REQ-013 SHALL issue at most one BRAM access per cycle: write (mem_enable=1, mem_write=1) or read (mem_enable=1, mem_write=0); otherwise mem_enable=0 and mem_write=0.
REQ-014 The output stage SHALL have states EMPTY, PENDING (read in flight) and FULL.
REQ-015 Transitions: EMPTY->PENDING on read issue; PENDING->FULL next cycle, capturing mem_data_out into rd_data; FULL->EMPTY on consume with no read issued; FULL->PENDING on consume with a read issued the same cycle.
REQ-016 A read SHALL be issued when the memory holds >=1 entry and the stage is EMPTY, or is FULL and being consumed this cycle.
REQ-017 A read issue SHALL take priority over a write: wr_ready = (mem_count < 1024) && !read_issue; wr_ready SHALL NOT depend on wr_valid.
REQ-018 rd_valid SHALL be 1 exactly in FULL.
REQ-019 Latency: a write accepted at cycle t into an empty FIFO SHALL give rd_valid=1 at t+2.
REQ-020 Sustained read throughput is one entry per 2 cycles (one-cycle bubble after each consume while the memory is non-empty); order SHALL be strictly FIFO.
REQ-021 Pointers SHALL wrap 1023->0; mem_count (0..1024, 11 bits) SHALL count entries in memory only, excluding the PENDING and FULL stage entries.
REQ-022 Full (mem_count=1024): wr_ready=0; a read issue in that cycle frees one entry, usable from the next cycle.
REQ-023 Empty memory with the stage FULL and consumed: stage goes to EMPTY and no access is issued.
REQ-024 wr_valid with wr_ready=0 SHALL cause no state change; the source holds wr_data.

Reset
REQ-025 While reset is high: pointers=0, mem_count=0, stage=EMPTY, rd_valid=0, wr_ready=0, mem_enable=0, mem_write=0, mem_addr=0.
REQ-026 Reset asserted mid-operation SHALL discard all entries, including one in flight; BRAM contents are not cleared.
REQ-027 wr_ready SHALL go to 1 in the first cycle after reset deasserts.

Configuration
REQ-028 Macro BRAM_FIFO_COUNT_EN: when defined, the block SHALL add an output port count (11 bits) = mem_count + 1 if the stage is PENDING or FULL, max 1025, reset 0; when undefined, the port and its logic SHALL be absent and all other behaviour identical.

Verification
REQ-029 After reset, write 0xA5 at t -> mem_write=1, mem_addr=0 at t; read with mem_addr=0 at t+1; rd_valid=1 and rd_data=0xA5 at t+2.
REQ-030 Write 1025 entries with rd_ready=0 -> 1024 held in memory plus 1 in FULL; wr_ready=0 once mem_count=1024; count=1025 with BRAM_FIFO_COUNT_EN.
REQ-031 Write 0x00..0xFF, then drain with rd_ready=1 -> output order 0x00..0xFF; rd_valid pattern 1,0,1,0...; final state EMPTY.
REQ-032 Continuous write and read for 3000 entries -> pointers wrap past 1023 with no data loss, and wr_ready=0 exactly in cycles with a read issue.
REQ-033 Assert reset while PENDING with 5 entries held -> rd_valid=0 and mem_enable=0 at once; after release, new write 0x3C is read back first.
